// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared types and constants for the RV32M multiply/divide
//               sequencer (funct3 op codes, FSM states, special results).
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    // Result of any divide-by-zero quotient, and of signed DIV overflow
    localparam logic [XLEN-1:0] DIV0_Q = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] OVF_Q  = 32'h8000_0000;

    // RV32M funct3 encodings
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_t;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

    // Divide-class operations have funct3[2] set
    function automatic logic op_is_div(input mdu_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    // Remainder-class operations return the remainder instead of the quotient
    function automatic logic op_is_rem(input mdu_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // Signed-division ops are the only ones that can overflow
    function automatic logic op_is_sdiv(input mdu_op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs1 is interpreted as signed
    function automatic logic op_a_signed(input mdu_op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is interpreted as signed
    function automatic logic op_b_signed(input mdu_op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ============================================================================
// Module      : mdu_step
// Description : One combinational iteration of the sequencer datapath.
//               Multiply: shift-add on {hi, multiplier}, one bit per call.
//               Divide  : restoring step on {remainder, dividend/quotient};
//                         the quotient bit is returned separately and the
//                         low bit of acc_o is left clear for it.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o,
    output logic              qbit_o
);

    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN-1:0] w_rem_sub;
    logic [XLEN-1:0] w_rem_new;
    logic            w_ge;

    // Compute both candidate iterations and select by operation class
    always_comb begin
        // Multiply: add multiplicand into the high half when the multiplier
        // LSB is set, then shift the whole accumulator right by one.
        w_mul_sum = {1'b0, acc_i[2*XLEN-1:XLEN]}
                  + (acc_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});

        // Divide: shift the next dividend bit into the partial remainder.
        // The shifted remainder can reach 33 bits; if its top bit is set it
        // is certainly >= divisor, and the 32-bit difference is exact
        // because the true difference is below the divisor.
        w_rem_sh  = acc_i[2*XLEN-1:XLEN-1];
        w_ge      = w_rem_sh[XLEN] | (w_rem_sh[XLEN-1:0] >= opnd_i);
        w_rem_sub = w_rem_sh[XLEN-1:0] - opnd_i;
        w_rem_new = w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0];

        if (is_div_i) begin
            acc_o  = {w_rem_new, acc_i[XLEN-2:0], 1'b0};
            qbit_o = w_ge;
        end else begin
            acc_o  = {w_mul_sum, acc_i[XLEN-1:1]};
            qbit_o = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
// Module      : mdu_seq
// Description : Iterative RV32M multiply/divide sequencer for Execute.
//               Accepts one M op, stalls the pipeline for 32 iterations
//               (plus the accept cycle), pulses done for one cycle with the
//               result. Divide-by-zero and signed overflow finish without
//               iterating.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_seq #(
    parameter int XLEN  = mdu_pkg::XLEN,
    parameter int CNT_W = mdu_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            startE,
    input  logic [2:0]      opE,
    input  logic [XLEN-1:0] opAE,
    input  logic [XLEN-1:0] opBE,
    input  logic            flushE,
    output logic            stallE,
    output logic            done,
    output logic [XLEN-1:0] result
);

    import mdu_pkg::*;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(XLEN - 1);

    // Architectural state
    mdu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [2*XLEN-1:0] acc_q,   acc_d;
    logic [XLEN-1:0]   opnd_q,  opnd_d;
    mdu_op_t           op_q,    op_d;
    logic              sa_q,    sa_d;
    logic              sb_q,    sb_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Incoming-operation decode
    mdu_op_t         w_op_in;
    logic            w_sa_in;
    logic            w_sb_in;
    logic [XLEN-1:0] w_maga_in;
    logic [XLEN-1:0] w_magb_in;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_special;

    // Iteration datapath and final correction
    logic [2*XLEN-1:0] w_acc_raw;
    logic              w_qbit;
    logic [2*XLEN-1:0] w_acc_step;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    mdu_step #(
        .XLEN (XLEN)
    ) u_step (
        .is_div_i (op_is_div(op_q)),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (w_acc_raw),
        .qbit_o   (w_qbit)
    );

    // Decode the operation waiting in Execute: signs, magnitudes, special cases
    always_comb begin
        w_op_in   = mdu_op_t'(opE);
        w_sa_in   = op_a_signed(w_op_in) & opAE[XLEN-1];
        w_sb_in   = op_b_signed(w_op_in) & opBE[XLEN-1];
        w_maga_in = w_sa_in ? (~opAE + 1'b1) : opAE;
        w_magb_in = w_sb_in ? (~opBE + 1'b1) : opBE;
        w_div0    = op_is_div(w_op_in) && (opBE == '0);
        w_ovf     = op_is_sdiv(w_op_in) && (opAE == OVF_Q) && (opBE == '1);
        if (w_div0) begin
            w_special = op_is_rem(w_op_in) ? opAE : DIV0_Q;
        end else begin
            w_special = op_is_rem(w_op_in) ? '0 : OVF_Q;
        end
    end

    // Merge the quotient bit and apply sign correction to the last iteration
    always_comb begin
        w_acc_step = {w_acc_raw[2*XLEN-1:1], w_acc_raw[0] | w_qbit};
        w_prod     = (sa_q ^ sb_q) ? (~w_acc_step + 1'b1) : w_acc_step;
        w_quo      = (sa_q ^ sb_q) ? (~w_acc_step[XLEN-1:0] + 1'b1)
                                   : w_acc_step[XLEN-1:0];
        w_rem      = sa_q ? (~w_acc_step[2*XLEN-1:XLEN] + 1'b1)
                          : w_acc_step[2*XLEN-1:XLEN];
        unique case (op_q)
            OP_MUL:                     w_final = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:                   w_final = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:            w_final = w_quo;
            OP_REM, OP_REMU:            w_final = w_rem;
            default:                    w_final = '0;
        endcase
    end

    // Next-state logic: accept, iterate, complete; flush overrides everything
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;

        unique case (state_q)
            ST_IDLE: begin
                if (startE) begin
                    op_d = w_op_in;
                    if (w_div0 || w_ovf) begin
                        result_d = w_special;
                        state_d  = ST_DONE;
                    end else begin
                        // Same layout for both classes: low half holds the
                        // multiplier / dividend, high half starts at zero.
                        acc_d   = {{XLEN{1'b0}}, w_maga_in};
                        opnd_d  = w_magb_in;
                        sa_d    = w_sa_in;
                        sb_d    = w_sb_in;
                        cnt_d   = '0;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d = w_acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_LAST) begin
                    result_d = w_final;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                // startE here still belongs to the completed instruction
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flushE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= OP_MUL;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
        end
    end

    // Pipeline handshake outputs
    always_comb begin
        stallE = ((state_q == ST_IDLE) && startE && !flushE) || (state_q == ST_CALC);
        done   = (state_q == ST_DONE);
        result = result_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_seq
// Description : Directed self-checking bench for mdu_seq. Inputs are driven
//               on the falling edge and outputs sampled 1 ns later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_seq;

    logic        clk;
    logic        rst_n;
    logic        startE;
    logic [2:0]  opE;
    logic [31:0] opAE;
    logic [31:0] opBE;
    logic        flushE;
    logic        stallE;
    logic        done;
    logic [31:0] result;

    int n_total = 0;
    int n_bad   = 0;

    mdu_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .startE (startE),
        .opE    (opE),
        .opAE   (opAE),
        .opBE   (opBE),
        .flushE (flushE),
        .stallE (stallE),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one M op and follow it to done, checking latency and result
    task automatic do_op(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_stall);
        int  stalls;
        int  done_at;
        bit  seen;
        @(negedge clk);
        startE = 1'b1; opE = op; opAE = a; opBE = b;
        #1;
        stalls  = 0;
        done_at = -1;
        seen    = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            if (done) begin
                seen    = 1'b1;
                done_at = i;
                chk({tag, " stall_at_done"}, 32'(stallE), 32'd0);
                chk({tag, " result"}, result, exp);
            end else if (stallE) begin
                stalls++;
            end
        end
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " stall_cycles"}, 32'(stalls), 32'(exp_stall));
        chk({tag, " done_cycle"}, 32'(done_at), 32'(exp_stall));
        startE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        rst_n = 1'b0; startE = 1'b0; opE = 3'd0; opAE = '0; opBE = '0; flushE = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset stallE", 32'(stallE), 32'd0);
        chk("reset done",   32'(done),   32'd0);
        chk("reset result", result,      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Non-M instructions never stall
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("nonM stallE", 32'(stallE), 32'd0);
        end

        // Multiply variants
        do_op("MUL 7x-3",   3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        do_op("MULHU -1x-1",3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        do_op("MULH -1x-1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        do_op("MULHSU -1xU",3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);

        // Divide variants
        do_op("DIV -7/2",   3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        do_op("REM -7/2",   3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        do_op("DIVU 100/7", 3'd5, 32'd100,       32'd7, 32'd14,        33);
        do_op("REMU 100/7", 3'd7, 32'd100,       32'd7, 32'd2,         33);

        // Special cases finish after the accept cycle
        do_op("DIVU 5/0",   3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        do_op("REM 5/0",    3'd6, 32'd5,         32'd0,         32'd5,         1);
        do_op("DIV ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("REM ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // Result holds after done
        repeat (3) @(negedge clk);
        #1;
        chk("result hold", result, 32'h0000_0000);
        do_op("MUL 9x9", 3'd0, 32'd9, 32'd9, 32'd81, 33);
        repeat (3) @(negedge clk);
        #1;
        chk("result hold 81", result, 32'd81);

        // Flush in CALC cycle 10
        @(negedge clk);
        startE = 1'b1; opE = 3'd0; opAE = 32'd5; opBE = 32'd5;
        repeat (10) @(negedge clk);
        flushE = 1'b1; startE = 1'b0;
        #1;
        chk("flush cycle stallE", 32'(stallE), 32'd1);
        @(negedge clk);
        flushE = 1'b0;
        #1;
        chk("after flush stallE", 32'(stallE), 32'd0);
        chk("after flush done",   32'(done),   32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (done) pulses++;
        end
        chk("flush no done", 32'(pulses), 32'd0);
        do_op("MUL 3x4", 3'd0, 32'd3, 32'd4, 32'd12, 33);

        // Reset in CALC cycle 20
        @(negedge clk);
        startE = 1'b1; opE = 3'd5; opAE = 32'd1000; opBE = 32'd3;
        repeat (20) @(negedge clk);
        #1;
        chk("pre-reset stallE", 32'(stallE), 32'd1);
        rst_n = 1'b0; startE = 1'b0;
        #1;
        chk("mid reset stallE", 32'(stallE), 32'd0);
        chk("mid reset done",   32'(done),   32'd0);
        chk("mid reset result", result,      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back: second op issued in the IDLE cycle after DONE
        do_op("b2b DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, 33);
        do_op("b2b MUL 6x7",    3'd0, 32'd6,   32'd7, 32'd42, 33);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
